// File: rtl/input_vc_buffer.sv
// Per-input-port virtual-channel flit buffer.
// Holds one FIFO per VC and presents a switch request and a latched output-port
// select for each VC to the allocator. It pops the granted VC's head flit onto a
// registered flit_out, which lines up with the allocator's registered crossbar
// grant, and returns one credit upstream for each popped flit.
module input_vc_buffer #(
    parameter int VC_NUM_PER_PORT    = 4,
    parameter int PORT_NUM           = 5,
    parameter int PORT_SEL_BCD_WIDTH = $clog2(PORT_NUM - 1),
    parameter int FLIT_WIDTH         = 34,
    parameter int VC_DEPTH           = 4
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic [FLIT_WIDTH-1:0]                           flit_in,
    input  logic                                            flit_in_wr,
    input  logic [VC_NUM_PER_PORT-1:0]                      flit_in_vc,
    output logic [VC_NUM_PER_PORT-1:0]                      in_vc_requests,
    output logic [VC_NUM_PER_PORT*PORT_SEL_BCD_WIDTH-1:0]   port_selects,
    input  logic [VC_NUM_PER_PORT-1:0]                      in_vc_granted,
    output logic [FLIT_WIDTH-1:0]                           flit_out,
    output logic                                            flit_out_wr,
    output logic [VC_NUM_PER_PORT-1:0]                      credit_out,
    output logic [VC_NUM_PER_PORT-1:0]                      vc_empty,
    output logic                                            overflow_err,
    output logic                                            grant_err
);
    localparam int V     = VC_NUM_PER_PORT;
    localparam int W     = PORT_SEL_BCD_WIDTH;
    localparam int PTR_W = $clog2(VC_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    // Bit FLIT_WIDTH-1 is set for header/single flits.
    // Bit FLIT_WIDTH-2 is set for tail/single flits.
    localparam int HDR_BIT  = FLIT_WIDTH - 1;
    localparam int TAIL_BIT = FLIT_WIDTH - 2;

    // Return the lowest set bit of a VC vector.
    function automatic logic [V-1:0] f_lowest(input logic [V-1:0] vec);
        return vec & (~vec + {{(V-1){1'b0}}, 1'b1});
    endfunction

    // Return true when exactly one bit of a VC vector is set.
    function automatic logic f_onehot(input logic [V-1:0] vec);
        return (vec != {V{1'b0}}) && ((vec & (vec - {{(V-1){1'b0}}, 1'b1})) == {V{1'b0}});
    endfunction

    logic [FLIT_WIDTH-1:0] r_mem [V][VC_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr [V];
    logic [PTR_W-1:0]      r_rd_ptr [V];
    logic [CNT_W-1:0]      r_count [V];
    logic [V-1:0]          r_route_valid;
    logic [W-1:0]          r_route [V];
    logic [FLIT_WIDTH-1:0] r_flit_out;
    logic                  r_flit_out_wr;
    logic [V-1:0]          r_credit;
    logic                  r_overflow_err;
    logic                  r_grant_err;

    logic [V-1:0]          w_empty;
    logic [V-1:0]          w_full;
    logic [V-1:0]          w_gnt_low;
    logic [V-1:0]          w_pop;
    logic [V-1:0]          w_wr;
    logic                  w_in_vc_ok;
    logic                  w_ovf_evt;
    logic                  w_gnt_evt;
    logic [FLIT_WIDTH-1:0] w_pop_flit;
    logic [PTR_W-1:0]      w_nxt_ptr [V];
    logic [V-1:0]          w_rv_nxt;
    logic [W-1:0]          w_rt_nxt [V];

    // Decode the write and pop strobes for each VC and detect error events.
    always_comb begin
        w_gnt_low  = f_lowest(in_vc_granted);
        w_in_vc_ok = f_onehot(flit_in_vc);
        w_empty    = {V{1'b0}};
        w_full     = {V{1'b0}};
        w_pop      = {V{1'b0}};
        w_wr       = {V{1'b0}};
        w_pop_flit = {FLIT_WIDTH{1'b0}};
        for (int v = 0; v < V; v++) begin
            w_empty[v] = (r_count[v] == {CNT_W{1'b0}});
            w_full[v]  = (r_count[v] == CNT_W'(VC_DEPTH));
            w_pop[v]   = w_gnt_low[v] & ~w_empty[v];
            // A full VC still accepts a write in an edge where it is also popped.
            w_wr[v]    = flit_in_wr & w_in_vc_ok & flit_in_vc[v] & (~w_full[v] | w_pop[v]);
            w_pop_flit = w_pop_flit | ({FLIT_WIDTH{w_pop[v]}} & r_mem[v][r_rd_ptr[v]]);
        end
        w_ovf_evt = flit_in_wr & (~w_in_vc_ok | (|(flit_in_vc & w_full & ~w_pop)));
        w_gnt_evt = (|in_vc_granted) & (~f_onehot(in_vc_granted) | (|(w_gnt_low & w_empty)));
    end

    // Work out the next route state of each VC from the head-of-queue changes.
    always_comb begin
        w_rv_nxt = r_route_valid;
        for (int v = 0; v < V; v++) begin
            w_rt_nxt[v]  = r_route[v];
            w_nxt_ptr[v] = r_rd_ptr[v] + {{(PTR_W-1){1'b0}}, 1'b1};
            if (w_wr[v] && w_empty[v]) begin
                // The new flit becomes the head of an empty VC.
                w_rv_nxt[v] = flit_in[HDR_BIT] ? 1'b1 : r_route_valid[v];
                w_rt_nxt[v] = flit_in[HDR_BIT] ? flit_in[W-1:0] : r_route[v];
            end else if (w_pop[v] && r_mem[v][r_rd_ptr[v]][TAIL_BIT]) begin
                if (r_count[v] == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                    // The last flit leaves. A flit written in the same edge becomes the head.
                    w_rv_nxt[v] = w_wr[v] & flit_in[HDR_BIT];
                    w_rt_nxt[v] = (w_wr[v] & flit_in[HDR_BIT]) ? flit_in[W-1:0] : r_route[v];
                end else begin
                    w_rv_nxt[v] = r_mem[v][w_nxt_ptr[v]][HDR_BIT];
                    w_rt_nxt[v] = r_mem[v][w_nxt_ptr[v]][HDR_BIT] ?
                                  r_mem[v][w_nxt_ptr[v]][W-1:0] : r_route[v];
                end
            end else begin
                // Body and tail flits leave the route unchanged.
                w_rv_nxt[v] = r_route_valid[v];
            end
        end
    end

    // Store accepted flits. The data array has no reset; the pointers track valid entries.
    always_ff @(posedge clk) begin
        for (int v = 0; v < V; v++) begin
            if (w_wr[v]) begin
                r_mem[v][r_wr_ptr[v]] <= flit_in;
            end
        end
    end

    // Update the FIFO pointers, occupancy and route state of each VC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int v = 0; v < V; v++) begin
                r_wr_ptr[v] <= {PTR_W{1'b0}};
                r_rd_ptr[v] <= {PTR_W{1'b0}};
                r_count[v]  <= {CNT_W{1'b0}};
                r_route[v]  <= {W{1'b0}};
            end
            r_route_valid <= {V{1'b0}};
        end else begin
            for (int v = 0; v < V; v++) begin
                if (w_wr[v]) begin
                    r_wr_ptr[v] <= r_wr_ptr[v] + {{(PTR_W-1){1'b0}}, 1'b1};
                end
                if (w_pop[v]) begin
                    r_rd_ptr[v] <= w_nxt_ptr[v];
                end
                r_count[v] <= r_count[v] + {{(CNT_W-1){1'b0}}, w_wr[v]}
                                         - {{(CNT_W-1){1'b0}}, w_pop[v]};
                r_route[v] <= w_rt_nxt[v];
            end
            r_route_valid <= w_rv_nxt;
        end
    end

    // Register the popped flit and its credit, one cycle after the grant edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flit_out    <= {FLIT_WIDTH{1'b0}};
            r_flit_out_wr <= 1'b0;
            r_credit      <= {V{1'b0}};
        end else begin
            r_flit_out_wr <= |w_pop;
            r_credit      <= w_pop;
            if (|w_pop) begin
                r_flit_out <= w_pop_flit;
            end
        end
    end

    // Sticky error flags. Only reset clears them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow_err <= 1'b0;
            r_grant_err    <= 1'b0;
        end else begin
            r_overflow_err <= r_overflow_err | w_ovf_evt;
            r_grant_err    <= r_grant_err | w_gnt_evt;
        end
    end

    assign in_vc_requests = ~w_empty & r_route_valid;
    assign vc_empty       = w_empty;
    assign flit_out       = r_flit_out;
    assign flit_out_wr    = r_flit_out_wr;
    assign credit_out     = r_credit;
    assign overflow_err   = r_overflow_err;
    assign grant_err      = r_grant_err;

    for (genvar g = 0; g < V; g++) begin : g_port_sel
        assign port_selects[g*W +: W] = r_route[g];
    end
endmodule

// File: tb/tb_input_vc_buffer.sv
// Scoreboard bench for input_vc_buffer.
// Stimulus tasks push the expected popped flit and credit into a queue.
// A negedge monitor pops the queue and compares whenever flit_out_wr is high.
module tb_input_vc_buffer;
    logic        clk = 1'b0;
    logic        reset;
    logic [33:0] flit_in;
    logic        flit_in_wr;
    logic [3:0]  flit_in_vc;
    logic [3:0]  in_vc_requests;
    logic [7:0]  port_selects;
    logic [3:0]  in_vc_granted;
    logic [33:0] flit_out;
    logic        flit_out_wr;
    logic [3:0]  credit_out;
    logic [3:0]  vc_empty;
    logic        overflow_err;
    logic        grant_err;

    typedef struct {
        logic [33:0] f;
        logic [3:0]  c;
    } exp_t;

    exp_t        sbq[$];
    logic [33:0] mq[4][$];
    int          n_vec = 0;
    int          n_bad = 0;
    int          n_credit = 0;
    int          n_pop_model = 0;
    bit          mon_en = 1'b0;

    always #5 clk = ~clk;

    input_vc_buffer dut (
        .clk(clk), .reset(reset), .flit_in(flit_in), .flit_in_wr(flit_in_wr),
        .flit_in_vc(flit_in_vc), .in_vc_requests(in_vc_requests),
        .port_selects(port_selects), .in_vc_granted(in_vc_granted),
        .flit_out(flit_out), .flit_out_wr(flit_out_wr), .credit_out(credit_out),
        .vc_empty(vc_empty), .overflow_err(overflow_err), .grant_err(grant_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare each popped flit and its credit against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            n_credit += $countones(credit_out);
            if (flit_out_wr) begin
                if (sbq.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_pop: got flit %0h expected none", flit_out);
                end else begin
                    e = sbq.pop_front();
                    chk("flit_out", flit_out, e.f);
                    chk("credit_out", credit_out, e.c);
                end
            end else if (credit_out != 4'b0000) begin
                chk("stray_credit", credit_out, 4'b0000);
            end
        end
    end

    // Apply one cycle of stimulus and update the reference FIFO model.
    task automatic step(input bit wr, input logic [3:0] vc, input logic [33:0] f,
                        input logic [3:0] g);
        int   pv;
        int   wi;
        bit   popping;
        bit   wacc;
        exp_t e;
        flit_in_wr    = wr;
        flit_in_vc    = vc;
        flit_in       = f;
        in_vc_granted = g;
        pv = -1;
        for (int i = 3; i >= 0; i--) if (g[i]) pv = i;
        wi = -1;
        for (int i = 0; i < 4; i++) if (vc[i]) wi = i;
        popping = (pv >= 0) && (mq[pv].size() > 0);
        wacc = wr && $onehot(vc) && ((mq[wi].size() < 4) || (popping && pv == wi));
        if (popping) begin
            e.f = mq[pv].pop_front();
            e.c = 4'b0001 << pv;
            sbq.push_back(e);
            n_pop_model++;
        end
        if (wacc) mq[wi].push_back(f);
        @(posedge clk);
        #1;
        flit_in_wr    = 1'b0;
        flit_in_vc    = 4'b0000;
        flit_in       = 34'h0;
        in_vc_granted = 4'b0000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [33:0] pk [5];
        logic [33:0] fl;
        int          wv;
        int          gv;
        logic [3:0]  er;

        reset = 1'b0;
        flit_in = 34'h0;
        flit_in_wr = 1'b0;
        flit_in_vc = 4'b0000;
        in_vc_granted = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        chk("rst_req", in_vc_requests, 4'b0000);
        chk("rst_ps", port_selects, 8'h00);
        chk("rst_flit", flit_out, 34'h0);
        chk("rst_wr", flit_out_wr, 1'b0);
        chk("rst_credit", credit_out, 4'b0000);
        chk("rst_empty", vc_empty, 4'b1111);
        chk("rst_errs", {overflow_err, grant_err}, 2'b00);
        reset = 1'b1;
        mon_en = 1'b1;

        // Single-flit packet on VC1, route 2'b11.
        step(1'b1, 4'b0010, {2'b11, 32'h0000_A5A3}, 4'b0000);
        @(negedge clk);
        chk("t1_req", in_vc_requests, 4'b0010);
        chk("t1_ps", port_selects[3:2], 2'b11);
        step(1'b0, 4'b0000, 34'h0, 4'b0010);
        @(negedge clk);
        chk("t1_wr", flit_out_wr, 1'b1);
        chk("t1_empty", vc_empty[1], 1'b1);
        chk("t1_req_clr", in_vc_requests, 4'b0000);

        // Four-flit packet on VC0, then a header written while the VC is full and popped.
        pk[0] = {2'b10, 32'hCAFE_0001};
        pk[1] = {2'b00, 32'hB0D1_0002};
        pk[2] = {2'b00, 32'hB0D2_0003};
        pk[3] = {2'b01, 32'h7A11_0003};
        pk[4] = {2'b10, 32'hCAFE_0002};
        for (int i = 0; i < 4; i++) step(1'b1, 4'b0001, pk[i], 4'b0000);
        @(negedge clk);
        chk("t2_ps0", port_selects[1:0], 2'b01);
        chk("t2_req", in_vc_requests, 4'b0001);
        for (int k = 0; k < 4; k++) begin
            step(k == 0, (k == 0) ? 4'b0001 : 4'b0000, pk[4], 4'b0001);
            @(negedge clk);
            chk("t2_wr", flit_out_wr, 1'b1);
            chk("t2_ps", port_selects[1:0], (k == 3) ? 2'b10 : 2'b01);
        end
        chk("t2_req_h2", in_vc_requests, 4'b0001);
        step(1'b0, 4'b0000, 34'h0, 4'b0001);
        @(negedge clk);
        chk("t2_empty", vc_empty, 4'b1111);
        chk("t2_errs", {overflow_err, grant_err}, 2'b00);

        // Interleaved single-flit packets with random one-hot grants.
        for (int c = 0; c < 200; c++) begin
            wv = $urandom_range(0, 3);
            gv = $urandom_range(0, 3);
            fl = {2'b11, $urandom()};
            step(($urandom_range(0, 1) == 1) && (mq[wv].size() < 4), 4'b0001 << wv, fl,
                 (($urandom_range(0, 3) != 0) && (mq[gv].size() > 0)) ? (4'b0001 << gv) : 4'b0000);
            @(negedge clk);
            for (int v = 0; v < 4; v++) er[v] = (mq[v].size() > 0);
            chk("rnd_req", in_vc_requests, er);
        end
        for (int v = 0; v < 4; v++) begin
            for (int k = 0; k < 4 && mq[v].size() > 0; k++) step(1'b0, 4'b0000, 34'h0, 4'b0001 << v);
        end
        @(negedge clk);
        #1;
        chk("rnd_credits", n_credit, n_pop_model);
        chk("rnd_sb_empty", sbq.size(), 0);
        chk("rnd_errs", {overflow_err, grant_err}, 2'b00);

        // Fill VC2, overflow it, then write and grant VC2 in the same edge.
        for (int i = 1; i <= 4; i++) step(1'b1, 4'b0100, {2'b11, 32'h2000_0000 + i}, 4'b0000);
        step(1'b1, 4'b0100, {2'b11, 32'h2000_0005}, 4'b0000);
        @(negedge clk);
        chk("t3_ovf", overflow_err, 1'b1);
        chk("t3_gerr0", grant_err, 1'b0);
        step(1'b1, 4'b0100, {2'b11, 32'h2000_0006}, 4'b0100);
        @(negedge clk);
        chk("t3_no_gerr", grant_err, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 4'b0000, 34'h0, 4'b0100);
        @(negedge clk);
        chk("t3_drained", vc_empty[2], 1'b1);

        // Grant to an empty VC, then a multi-hot grant.
        step(1'b0, 4'b0000, 34'h0, 4'b1000);
        @(negedge clk);
        chk("t4_no_pop", flit_out_wr, 1'b0);
        chk("t4_gerr", grant_err, 1'b1);
        step(1'b1, 4'b0010, {2'b11, 32'h1000_0001}, 4'b0000);
        step(1'b1, 4'b0100, {2'b11, 32'h2000_0001}, 4'b0000);
        step(1'b0, 4'b0000, 34'h0, 4'b0110);
        @(negedge clk);
        chk("t4_multi_wr", flit_out_wr, 1'b1);
        chk("t4_empty", vc_empty, 4'b1011);
        step(1'b0, 4'b0000, 34'h0, 4'b0100);

        // Assert reset between edges while VC0 holds 3 flits and a pop is on flit_out.
        for (int i = 0; i < 3; i++) step(1'b1, 4'b0001, {2'b10, 32'h0E00_0000 + i}, 4'b0000);
        step(1'b1, 4'b0001, {2'b00, 32'h0E00_0003}, 4'b0001);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_req", in_vc_requests, 4'b0000);
        chk("t6_ps", port_selects, 8'h00);
        chk("t6_flit", flit_out, 34'h0);
        chk("t6_wr", flit_out_wr, 1'b0);
        chk("t6_credit", credit_out, 4'b0000);
        chk("t6_empty", vc_empty, 4'b1111);
        chk("t6_errs", {overflow_err, grant_err}, 2'b00);
        sbq.delete();
        for (int v = 0; v < 4; v++) mq[v].delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_post_empty", vc_empty, 4'b1111);
        chk("t6_post_req", in_vc_requests, 4'b0000);
        chk("final_sb_empty", sbq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
